// File: rtl/f1_start_seq.sv
// Start-light sequencer and reaction timer: lamps fill one per tick, hold for an
// LFSR-chosen number of ticks, then count clk cycles until the player reacts.
module f1_start_seq #(
  parameter int N_LIGHTS = 8,
  parameter int RND_W    = 7,
  parameter int TIME_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                tick,
  input  logic [RND_W-1:0]    rnd,
  input  logic                react,
  output logic                rnd_en,
  output logic [N_LIGHTS-1:0] lights,
  output logic                busy,
  output logic                time_valid,
  output logic [TIME_W-1:0]   react_time,
  output logic                jump_start
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_GO   = 2'd3;

  logic [1:0]        state;
  logic [RND_W-1:0]  delay;
  logic [TIME_W-1:0] timer;

  // The LFSR free-runs until the hold length is latched, then freezes.
  assign rnd_en = (state == S_IDLE) || (state == S_SEQ);
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      lights     <= '0;
      delay      <= '0;
      timer      <= '0;
      react_time <= '0;
      time_valid <= 1'b0;
      jump_start <= 1'b0;
    end else begin
      time_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          lights <= '0;
          if (trigger) begin
            state      <= S_SEQ;
            jump_start <= 1'b0;
          end
        end
        S_SEQ: begin
          if (react) begin
            state      <= S_IDLE;
            lights     <= '0;
            jump_start <= 1'b1;
          end else if (tick) begin
            lights <= {lights[N_LIGHTS-2:0], 1'b1};
            // Bit N_LIGHTS-2 already lit means this tick lights the last lamp.
            if (lights[N_LIGHTS-2]) begin
              state <= S_HOLD;
              delay <= (rnd == '0) ? RND_W'(1) : rnd;
            end
          end
        end
        S_HOLD: begin
          if (react) begin
            state      <= S_IDLE;
            lights     <= '0;
            jump_start <= 1'b1;
          end else if (tick) begin
            if (delay == RND_W'(1)) begin
              state  <= S_GO;
              lights <= '0;
              timer  <= '0;
            end else begin
              delay <= delay - RND_W'(1);
            end
          end
        end
        default: begin
          lights <= '0;
          if (react) begin
            react_time <= timer;
            time_valid <= 1'b1;
            state      <= S_IDLE;
          end else if (timer != '1) begin
            timer <= timer + TIME_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f1_start_seq.sv
// Bench for f1_start_seq: directed scenarios with random tick pacing, LFSR words and
// reaction delays, checked every cycle against a phase/count reference model.
module tb_f1_start_seq;

  localparam int N      = 8;
  localparam int RW     = 7;
  localparam int TW     = 16;
  localparam int TW_SAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trigger = 1'b0, tick = 1'b0, react = 1'b0;
  logic [RW-1:0] rnd = '0;

  logic              rnd_en_a, busy_a, tv_a, js_a;
  logic [N-1:0]      lights_a;
  logic [TW-1:0]     rt_a;
  logic              rnd_en_b, busy_b, tv_b, js_b;
  logic [N-1:0]      lights_b;
  logic [TW_SAT-1:0] rt_b;

  f1_start_seq #(.N_LIGHTS(N), .RND_W(RW), .TIME_W(TW)) dut_a (
    .clk(clk), .rst(rst), .trigger(trigger), .tick(tick), .rnd(rnd), .react(react),
    .rnd_en(rnd_en_a), .lights(lights_a), .busy(busy_a), .time_valid(tv_a),
    .react_time(rt_a), .jump_start(js_a));

  // Same stimulus into a narrow-timer copy to exercise saturation.
  f1_start_seq #(.N_LIGHTS(N), .RND_W(RW), .TIME_W(TW_SAT)) dut_b (
    .clk(clk), .rst(rst), .trigger(trigger), .tick(tick), .rnd(rnd), .react(react),
    .rnd_en(rnd_en_b), .lights(lights_b), .busy(busy_b), .time_valid(tv_b),
    .react_time(rt_b), .jump_start(js_b));

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  int rnd_force = -1;

  // Reference model: 0 idle, 1 lamps filling, 2 holding, 3 waiting for reaction.
  int m_phase, m_lit, m_hold, m_go, m_rt;
  bit m_jump, m_tv;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_lit = 0; m_hold = 0; m_go = 0; m_rt = 0; m_jump = 0; m_tv = 0;
  endtask

  task automatic model_step(input bit trg, input bit tk, input bit r, input int rv);
    m_tv = 0;
    case (m_phase)
      0: if (trg) begin m_phase = 1; m_lit = 0; m_jump = 0; end
      1, 2: begin
        if (r) begin
          m_phase = 0; m_lit = 0; m_jump = 1;
        end else if (tk && m_phase == 1) begin
          m_lit++;
          if (m_lit == N) begin m_phase = 2; m_hold = (rv == 0) ? 1 : rv; end
        end else if (tk) begin
          m_hold--;
          if (m_hold == 0) begin m_phase = 3; m_lit = 0; m_go = 0; end
        end
      end
      default: begin
        if (r) begin m_rt = m_go; m_tv = 1; m_phase = 0; end
        else m_go++;
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [N-1:0] exp_l;
    exp_l = '0;
    for (int i = 0; i < m_lit; i++) exp_l[i] = 1'b1;
    chk("lights", 32'(lights_a), 32'(exp_l));
    chk("busy", 32'(busy_a), 32'(m_phase != 0));
    chk("rnd_en", 32'(rnd_en_a), 32'(m_phase <= 1));
    chk("time_valid", 32'(tv_a), 32'(m_tv));
    chk("jump_start", 32'(js_a), 32'(m_jump));
    chk("react_time", 32'(rt_a), 32'(sat(m_rt, TW)));
    chk("react_time_sat", 32'(rt_b), 32'(sat(m_rt, TW_SAT)));
    chk("lights_sat", 32'(lights_b), 32'(exp_l));
  endtask

  task automatic cyc(input bit trg, input bit tk, input bit r);
    @(negedge clk);
    trigger = trg; tick = tk; react = r;
    rnd = (rnd_force < 0) ? RW'($urandom) : RW'(rnd_force);
    @(posedge clk);
    model_step(trg, tk, r, int'(rnd));
    #1;
    check_all();
  endtask

  task automatic timeout(input string tag);
    nvec++; nerr++;
    $error("FAIL %s observed=timeout expected=progress", tag);
  endtask

  // One game: trigger, pace ticks every tp clocks, optionally jump start at a lamp
  // count (jl) or on a HOLD tick (jh), else react rd cycles after lamps go out.
  task automatic run(input int tp, input int rf, input int rd, input int jl,
                     input bit jh, input bit trig_react);
    int c, budget;
    bit tk, r;
    rnd_force = rf;
    cyc(1'b1, 1'b1, trig_react);
    c = 0; budget = 3000;
    while (m_phase != 3 && m_phase != 0 && budget > 0) begin
      c++; budget--;
      tk = (c % tp == 0);
      r = (jl > 0 && m_phase == 1 && m_lit == jl) || (jh && m_phase == 2 && tk);
      cyc(1'b0, tk, r);
    end
    if (budget == 0) timeout("seq_hold");
    if (m_phase == 3) begin
      for (int i = 1; i < rd; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
    end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    @(negedge clk); rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);

    // Normal run: rnd 5, tick every 4 clk, react 10 clk after lamps out.
    rnd_force = 5;
    cyc(1'b1, 1'b1, 1'b0);
    for (int l = 1; l <= N; l++) begin
      for (int k = 1; k < 4; k++) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      chk("lamp_step", 32'(lights_a), (32'd1 << l) - 1);
    end
    for (int h = 1; h <= 5; h++) begin
      for (int k = 1; k < 4; k++) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
    end
    chk("lamps_out", 32'(lights_a), 32'd0);
    for (int i = 1; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("rt_normal", 32'(rt_a), 32'd9);
    chk("tv_normal", 32'(tv_a), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("busy_done", 32'(busy_a), 32'd0);

    // rnd 0 -> single-tick hold; trigger+react together enters SEQ.
    run(2, 0, 3, 0, 1'b0, 1'b1);
    // Jump start after the 3rd lamp, then the next trigger clears the flag.
    run(3, -1, 5, 3, 1'b0, 1'b0);
    chk("jump_flag", 32'(js_a), 32'd1);
    run(1, -1, 1, 0, 1'b1, 1'b0);
    chk("jump_hold_flag", 32'(js_a), 32'd1);
    // Saturation: 40 cycles in GO before react.
    run(1, 2, 41, 0, 1'b0, 1'b0);
    chk("rt_sat4", 32'(rt_b), 32'd15);
    chk("rt_wide", 32'(rt_a), 32'd40);

    // Randomised games.
    for (int g = 0; g < 14; g++) begin
      int sel;
      sel = $urandom_range(0, 5);
      run($urandom_range(1, 4), -1, $urandom_range(1, 30),
          (sel == 0) ? $urandom_range(1, N - 1) : 0, sel == 1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Async reset mid-HOLD, applied off-edge.
    rnd_force = 100;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < N + 3; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("in_hold", 32'(rnd_en_a), 32'd0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk); rst = 1'b0;
    run(2, 5, 7, 0, 1'b0, 1'b0);
    chk("rt_after_reset", 32'(rt_a), 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
